// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA pipeline widths, text-grid geometry and timing-bus layout
package vga_pkg;

   localparam int CNT_W     = 11;  // hcount / vcount width
   localparam int RGB_W     = 12;  // RGB444
   localparam int FONT_W    = 8;
   localparam int FONT_H    = 16;
   localparam int GRID_COLS = 16;
   localparam int GRID_ROWS = 16;

   // Timing bus field order, MSB first.
   typedef struct packed {
      logic [CNT_W-1:0] hcount;
      logic [CNT_W-1:0] vcount;
      logic             hsync;
      logic             vsync;
      logic             hblnk;
      logic             vblnk;
   } vga_timing_t;

endpackage

// File: rtl/vga_delay.sv
// rtl/vga_delay.sv - fixed-latency delay line for timing/rgb buses
// Ports: clk, rst_n (async, active low), din[WIDTH] -> dout[WIDTH] delayed CLK_DEL cycles.
module vga_delay #(
   parameter int WIDTH   = 8,
   parameter int CLK_DEL = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] stage [CLK_DEL];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < CLK_DEL; i++) stage[i] <= '0;
      end else begin
         stage[0] <= din;
         for (int i = 1; i < CLK_DEL; i++) stage[i] <= stage[i-1];
      end
   end

   assign dout = stage[CLK_DEL-1];

endmodule

// File: rtl/char_grid_reader.sv
// rtl/char_grid_reader.sv - 16x16 character-grid text overlay, 3-cycle VGA pipeline stage
// Ports: pclk, rst_n (async, active low); hcount/vcount/sync/blnk/rgb _in -> _out (3 cycles later);
//        char_xy/char_line address the external char/font ROMs; char_code (comb from char ROM, used
//        only by the font ROM outside this block); char_pixels = registered font row, bit 7 leftmost.
module char_grid_reader
   import vga_pkg::*;
#(
   parameter int               XPOS       = 100,
   parameter int               YPOS       = 100,
   parameter logic [RGB_W-1:0] TEXT_COLOR = 12'hfff
) (
   input  logic             pclk,
   input  logic             rst_n,
   input  logic [CNT_W-1:0] hcount_in,
   input  logic [CNT_W-1:0] vcount_in,
   input  logic             hsync_in,
   input  logic             vsync_in,
   input  logic             hblnk_in,
   input  logic             vblnk_in,
   input  logic [RGB_W-1:0] rgb_in,
   input  logic [7:0]       char_pixels,
   input  logic [6:0]       char_code,
   output logic [7:0]       char_xy,
   output logic [3:0]       char_line,
   output logic [CNT_W-1:0] hcount_out,
   output logic [CNT_W-1:0] vcount_out,
   output logic             hsync_out,
   output logic             vsync_out,
   output logic             hblnk_out,
   output logic             vblnk_out,
   output logic [RGB_W-1:0] rgb_out
);

   localparam int RECT_W = FONT_W * GRID_COLS;   // 128 px
   localparam int RECT_H = FONT_H * GRID_ROWS;   // 256 lines

   generate
      if (XPOS + RECT_W > 2047 || YPOS + RECT_H > 2047) begin : g_bad_geometry
         $error("char_grid_reader: text rectangle exceeds the 11-bit counter range");
      end
   endgenerate

   localparam logic [CNT_W-1:0] X_LO = CNT_W'(XPOS);
   localparam logic [CNT_W-1:0] X_HI = CNT_W'(XPOS + RECT_W);
   localparam logic [CNT_W-1:0] Y_LO = CNT_W'(YPOS);
   localparam logic [CNT_W-1:0] Y_HI = CNT_W'(YPOS + RECT_H);

   // Per-pixel data that must line up with the registered font row.
   typedef struct packed {
      logic             in_rect;
      logic [2:0]       xbit;
      logic             hblnk;
      logic             vblnk;
      logic [RGB_W-1:0] rgb;
   } pix_t;

   logic [CNT_W-1:0] dx, dy;
   logic             in_rect;
   vga_timing_t      timing_in, timing_out;
   pix_t             pix_in, pix_d2;

   assign dx      = hcount_in - X_LO;
   assign dy      = vcount_in - Y_LO;
   assign in_rect = (hcount_in >= X_LO) && (hcount_in < X_HI) &&
                    (vcount_in >= Y_LO) && (vcount_in < Y_HI);

   // char_code feeds the font ROM directly; upper geometry bits are outside the grid.
   logic unused_bits;
   assign unused_bits = ^{char_code, dx[CNT_W-1:7], dy[CNT_W-1:8]};

   // Stage 1: grid address for the char ROM and font line for the font ROM.
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         char_xy   <= 8'h00;
         char_line <= 4'h0;
      end else begin
         char_xy   <= in_rect ? {dy[7:4], dx[6:3]} : 8'h00;
         char_line <= in_rect ? dy[3:0] : 4'h0;
      end
   end

   assign timing_in = '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in,
                        vsync: vsync_in, hblnk: hblnk_in, vblnk: vblnk_in};

   vga_delay #(.WIDTH($bits(vga_timing_t)), .CLK_DEL(3)) u_timing_delay (
      .clk (pclk),
      .rst_n (rst_n),
      .din (timing_in),
      .dout (timing_out)
   );

   assign pix_in = '{in_rect: in_rect, xbit: dx[2:0], hblnk: hblnk_in,
                     vblnk: vblnk_in, rgb: rgb_in};

   // Two cycles: matches the char ROM (comb) + font ROM (registered) path.
   vga_delay #(.WIDTH($bits(pix_t)), .CLK_DEL(2)) u_pix_delay (
      .clk (pclk),
      .rst_n (rst_n),
      .din (pix_in),
      .dout (pix_d2)
   );

   // Stage 3: blanking overrides text; font bit 7 is the leftmost pixel of a cell.
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         rgb_out <= '0;
      end else if (pix_d2.hblnk || pix_d2.vblnk) begin
         rgb_out <= '0;
      end else if (pix_d2.in_rect && char_pixels[3'd7 - pix_d2.xbit]) begin
         rgb_out <= TEXT_COLOR;
      end else begin
         rgb_out <= pix_d2.rgb;
      end
   end

   assign hcount_out = timing_out.hcount;
   assign vcount_out = timing_out.vcount;
   assign hsync_out  = timing_out.hsync;
   assign vsync_out  = timing_out.vsync;
   assign hblnk_out  = timing_out.hblnk;
   assign vblnk_out  = timing_out.vblnk;

endmodule

// File: tb/tb_char_grid_reader.sv
// tb/tb_char_grid_reader.sv - self-checking bench for char_grid_reader
module tb_char_grid_reader;

   logic        pclk = 1'b0;
   logic        rst_n = 1'b0;
   logic [10:0] hcount_in = '0, vcount_in = '0;
   logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
   logic [11:0] rgb_in = '0;
   logic [7:0]  char_pixels = '0;
   logic [6:0]  char_code;
   logic [7:0]  char_xy;
   logic [3:0]  char_line;
   logic [10:0] hcount_out, vcount_out;
   logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
   logic [11:0] rgb_out;

   int checks = 0;
   int errors = 0;

   logic       font_const_en = 1'b1;
   logic [7:0] font_const = 8'h00;

   always #5 pclk = ~pclk;

   char_grid_reader #(.XPOS(100), .YPOS(100), .TEXT_COLOR(12'hfff)) dut (
      .pclk (pclk), .rst_n (rst_n),
      .hcount_in (hcount_in), .vcount_in (vcount_in),
      .hsync_in (hsync_in), .vsync_in (vsync_in), .hblnk_in (hblnk_in), .vblnk_in (vblnk_in),
      .rgb_in (rgb_in), .char_pixels (char_pixels), .char_code (char_code),
      .char_xy (char_xy), .char_line (char_line),
      .hcount_out (hcount_out), .vcount_out (vcount_out),
      .hsync_out (hsync_out), .vsync_out (vsync_out), .hblnk_out (hblnk_out), .vblnk_out (vblnk_out),
      .rgb_out (rgb_out)
   );

   // Char ROM: every cell holds 7'h0c. Font ROM: one-cycle registered lookup.
   assign char_code = 7'h0c;

   function automatic logic [7:0] font_row(input logic [6:0] code, input logic [3:0] line);
      return {line, ~line} ^ {1'b0, code};
   endfunction

   always @(posedge pclk)
      char_pixels <= font_const_en ? font_const : font_row(char_code, char_line);

   typedef struct {
      logic [25:0] timing;
      logic [11:0] rgb;
      logic [7:0]  xy;
      logic [3:0]  line;
   } exp_t;

   exp_t pipe [3];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Independent golden model of one pixel.
   function automatic exp_t model(input int h, input int v, input logic hs, input logic vs,
                                  input logic hb, input logic vb, input logic [11:0] rgb);
      exp_t e;
      bit   inr;
      int   bitpos;
      logic [7:0] f;
      inr = (h >= 100) && (h < 228) && (v >= 100) && (v < 356);
      e.timing = {h[10:0], v[10:0], hs, vs, hb, vb};
      e.xy   = inr ? 8'((((v - 100) / 16) << 4) | ((h - 100) / 8)) : 8'h00;
      e.line = inr ? 4'((v - 100) % 16) : 4'h0;
      bitpos = (h - 100) % 8;
      f = font_const_en ? font_const : font_row(7'h0c, e.line);
      if (hb || vb)                 e.rgb = 12'h000;
      else if (inr && f[7 - bitpos]) e.rgb = 12'hfff;
      else                          e.rgb = rgb;
      return e;
   endfunction

   task automatic pix(input int h, input int v, input logic hs, input logic vs,
                      input logic hb, input logic vb, input logic [11:0] rgb);
      exp_t e;
      hcount_in = 11'(h); vcount_in = 11'(v);
      hsync_in = hs; vsync_in = vs; hblnk_in = hb; vblnk_in = vb; rgb_in = rgb;
      if (!rst_n) begin
         e = '{timing: '0, rgb: '0, xy: '0, line: '0};
         for (int i = 0; i < 3; i++) pipe[i] = e;
      end else begin
         e = model(h, v, hs, vs, hb, vb, rgb);
      end
      @(posedge pclk);
      #1;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = e;
      chk("char_xy", 32'(char_xy), 32'(pipe[0].xy));
      chk("char_line", 32'(char_line), 32'(pipe[0].line));
      chk("rgb_out", 32'(rgb_out), 32'(pipe[2].rgb));
      chk("timing_out", 32'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}),
          32'(pipe[2].timing));
   endtask

   task automatic flush();
      for (int i = 0; i < 4; i++) pix(10 + i, 20, 1'b0, 1'b0, 1'b0, 1'b0, 12'h123);
   endtask

   initial begin
      for (int i = 0; i < 3; i++) pipe[i] = '{timing: '0, rgb: '0, xy: '0, line: '0};
      #1;
      // Power-up reset, then release.
      for (int i = 0; i < 3; i++) pix(150, 150, 1'b1, 1'b1, 1'b0, 1'b0, 12'habc);
      rst_n = 1'b1;
      font_const = 8'h80;
      flush();

      // 1: reset mid-frame for 5 cycles with busy inputs, then hsync latency.
      for (int i = 0; i < 3; i++) pix(150 + i, 150, 1'b1, 1'b0, 1'b0, 1'b0, 12'habc);
      rst_n = 1'b0;
      for (int i = 0; i < 5; i++) begin
         pix(160 + i, 150, 1'b1, 1'b1, 1'b0, 1'b0, 12'habc);
         chk("rst_rgb_zero", 32'(rgb_out), 32'h0);
         chk("rst_hsync_zero", 32'(hsync_out), 32'h0);
      end
      rst_n = 1'b1;
      pix(300, 20, 1'b1, 1'b0, 1'b0, 1'b0, 12'h111);
      chk("hs_lat_c1", 32'(hsync_out), 32'h0);
      pix(301, 20, 1'b1, 1'b0, 1'b0, 1'b0, 12'h111);
      chk("hs_lat_c2", 32'(hsync_out), 32'h0);
      pix(302, 20, 1'b1, 1'b0, 1'b0, 1'b0, 12'h111);
      chk("hs_lat_c3", 32'(hsync_out), 32'h1);
      flush();

      // 2: corner addresses.
      pix(100, 100, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0a0);
      chk("xy_first", 32'(char_xy), 32'h00);
      chk("line_first", 32'(char_line), 32'h0);
      pix(227, 355, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0a0);
      chk("xy_last", 32'(char_xy), 32'hff);
      chk("line_last", 32'(char_line), 32'hf);
      flush();

      // 3: font 8'b1000_0000 lights only the leftmost pixel of the cell.
      for (int h = 100; h < 108; h++) pix(h, 100, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0a0);
      chk("text_px100", 32'(rgb_out), 32'h0a0);  // pixel 105 at the output now
      pix(108, 100, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0a0);
      pix(109, 100, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0a0);
      pix(110, 100, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0a0);
      chk("text_px108", 32'(rgb_out), 32'hfff);
      flush();

      // 4: just outside left and right edges.
      pix(99, 150, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0a0);
      chk("xy_left_out", 32'(char_xy), 32'h00);
      pix(228, 150, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0a0);
      chk("xy_right_out", 32'(char_xy), 32'h00);
      pix(228, 150, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0a0);
      pix(228, 150, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0a0);
      chk("rgb_right_pass", 32'(rgb_out), 32'h0a0);
      flush();

      // 5: blanking wins inside the rectangle with all font bits set.
      font_const = 8'hff;
      pix(150, 150, 1'b0, 1'b0, 1'b1, 1'b0, 12'h0a0);
      pix(151, 150, 1'b0, 1'b0, 1'b0, 1'b1, 12'h0a0);
      pix(152, 150, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0a0);
      chk("blank_h", 32'(rgb_out), 32'h000);
      pix(153, 150, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0a0);
      chk("blank_v", 32'(rgb_out), 32'h000);
      pix(154, 150, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0a0);
      chk("unblank_text", 32'(rgb_out), 32'hfff);
      flush();

      // 6: 800x600 frame scan (every 7th line) with the char ROM/font model.
      font_const_en = 1'b0;
      flush();
      for (int v = 0; v < 600; v += 7) begin
         for (int h = 0; h < 800; h++) begin
            pix(h, v, (h >= 656 && h < 752), (v >= 490 && v < 492),
                (h >= 640), (v >= 480), {4'(h), 4'(v), 4'(h >> 4)});
         end
      end
      flush();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
